// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MDU opcode/state types and iteration count
package mips_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_ITER = 32;

  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-divide iteration
module mdu_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem, quo[31]};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    // A borrow out of bit 33 means the trial subtraction failed; restore.
    if (diff[33]) begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32x32 multiply/divide unit with HI/LO; divide enabled by MDU_DIV_EN
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  mdu_state_t  state, state_next;
  mdu_op_t     op_e;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_next, prod_fix;
  logic [31:0] opnd_q, in_mag_a, in_mag_b, res_hi, res_lo;
  logic [32:0] mul_sum;
  logic        sign_q, in_signed, in_neg_a, in_neg_b, legal;

  assign op_e      = mdu_op_t'(op);
  assign in_signed = (op_e == MULT) || (op_e == DIV);
  assign in_neg_a  = in_signed & rs_val[31];
  assign in_neg_b  = in_signed & rt_val[31];
  assign in_mag_a  = mdu_abs(rs_val, in_neg_a);
  assign in_mag_b  = mdu_abs(rt_val, in_neg_b);

  // Shift-add on magnitudes: multiplier sits in the low half, product grows from the top.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
  assign prod_fix = sign_q ? (~acc + 64'd1) : acc;

`ifdef MDU_DIV_EN
  logic        is_div_q, neg_a_q, dz_q;
  logic [31:0] a_q, rem_next, quo_next;

  mdu_div_step u_div_step (
    .rem      (acc[63:32]),
    .quo      (acc[31:0]),
    .divisor  (opnd_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign legal       = 1'b1;
  assign acc_next    = is_div_q ? {rem_next, quo_next} : {mul_sum, acc[31:1]};
  assign div_by_zero = done & is_div_q & dz_q;
`else
  assign legal       = (op_e == MULT) || (op_e == MULTU);
  assign acc_next    = {mul_sum, acc[31:1]};
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      if (dz_q) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = mdu_abs(acc[63:32], neg_a_q);
        res_lo = mdu_abs(acc[31:0], sign_q);
      end
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && legal) state_next = RUN;
      RUN:  if (cnt == 5'(MDU_ITER - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd_q <= 32'd0;
      sign_q <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= 32'd0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (mthi) hi <= wr_data;
          if (mtlo) lo <= wr_data;
          if (start && legal) begin
            cnt    <= 5'd0;
            sign_q <= in_neg_a ^ in_neg_b;
            // Multiply keeps the multiplicand aside; divide keeps the divisor aside.
            opnd_q <= op[1] ? in_mag_b : in_mag_a;
            acc    <= {32'd0, op[1] ? in_mag_a : in_mag_b};
`ifdef MDU_DIV_EN
            is_div_q <= op[1];
            neg_a_q  <= in_neg_a;
            dz_q     <= (rt_val == 32'd0);
            a_q      <= rs_val;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit; divide vectors run when MDU_DIV_EN is defined
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat;
  logic seen;

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick;
    start = 1'b0;
    rs_val = 32'h1234_5678;
    rt_val = 32'h0000_0009;
  endtask

  task automatic finish_wait(inout int n);
    while (n < 40) begin
      tick;
      n++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int n;
    launch(o, a, b);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    finish_wait(n);
    chk({tag, "_lat"}, n, 32'd33);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
    tick;
    chk({tag, "_done_clr"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; rs_val = 32'd0; rt_val = 32'd0; wr_data = 32'd0;
    tick; tick;
    rst = 1'b0;
    chk("rst_state", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_pos_neg", 2'd0, 32'h0000_1000, 32'h8000_0000, 32'hFFFF_F800, 32'h0000_0000, 1'b0);

`ifdef MDU_DIV_EN
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_big", 2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
`endif

    // Start and mtlo pulsed mid-run must be ignored.
    launch(2'd1, 32'd3, 32'd5);
    repeat (10) tick;
    start = 1'b1; op = 2'd1; rs_val = 32'd7; rt_val = 32'd7;
    mtlo = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick;
    start = 1'b0; mtlo = 1'b0;
    lat = 11;
    finish_wait(lat);
    chk("ign_lat", lat, 32'd33);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    tick;
    chk("ign_no_restart", {31'd0, busy}, 32'd0);

    mthi = 1'b1; wr_data = 32'hA5A5_A5A5;
    tick;
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo", lo, 32'd15);

`ifndef MDU_DIV_EN
    launch(2'd3, 32'd7, 32'd1);
    chk("illegal_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick;
      seen = seen | done | busy;
    end
    chk("illegal_no_done", {31'd0, seen}, 32'd0);
    chk("illegal_hi", hi, 32'hA5A5_A5A5);
    chk("illegal_lo", lo, 32'd15);
`endif

    // Reset mid-operation aborts with no later done pulse.
`ifdef MDU_DIV_EN
    launch(2'd2, 32'd100, 32'd7);
`else
    launch(2'd1, 32'd100, 32'd7);
`endif
    repeat (20) tick;
    start = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", {30'd0, busy, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick;
      seen = seen | done;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    chk("abort_lo_hold", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-005 SHALL have ports rs_val and rt_val, input, 32 bits each: operand A (multiplicand/dividend) and operand B (multiplier/divisor).
REQ-006 SHALL have ports mthi and mtlo, input, 1 bit each, and wr_data, input, 32 bits: direct HI/LO register writes.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-010 SHALL have port div_by_zero, output, 1 bit: asserted with done when a divide had rt_val==0.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE; IDLE->RUN on start with a legal op, RUN->FIX after 32 iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-012 SHALL latch op, rs_val and rt_val on the edge that samples start in IDLE; later operand changes have no effect.
REQ-013 SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle in RUN, counter 0..31.
REQ-014 SHALL, for signed ops, iterate on magnitudes and apply sign correction in FIX.
REQ-015 SHALL load hi/lo on the edge entering DONE; done is high exactly the cycle after the 33rd rising edge following the start sample.
REQ-016 SHALL produce, for MULT/MULTU, {hi,lo} = full 64-bit signed/unsigned product.
REQ-017 SHALL produce, for DIV/DIVU, lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-018 SHALL, on divide by zero, give hi = rs_val, lo = 32'hFFFFFFFF and pulse div_by_zero with done.
REQ-019 SHALL give, for DIV 32'h80000000 / 32'hFFFFFFFF, lo = 32'h80000000 and hi = 0.
REQ-020 SHALL ignore start, mthi and mtlo while busy is high.
REQ-021 SHALL, in IDLE, load hi from wr_data on mthi and lo from wr_data on mtlo in the next edge; if start and mthi/mtlo coincide, the write is applied and the operation also starts.
REQ-022 SHALL hold hi/lo stable in all states except on the DONE-entry edge and accepted mthi/mtlo writes.

Reset
REQ-023 SHALL, when rst is high at a rising edge, force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-024 SHALL, on reset mid-operation, abort the operation; no done pulse and no hi/lo update follow.
REQ-025 SHALL give rst priority over start, mthi and mtlo in the same cycle.

Configuration
REQ-026 SHALL, with macro MDU_DIV_EN defined, support DIV and DIVU as specified.
REQ-027 SHALL, without MDU_DIV_EN, treat start with op DIV/DIVU as illegal: the request is ignored, busy stays low, div_by_zero is tied 0, and no divider logic is synthesised.

Structure
REQ-028 SHALL place in shared package mips_pkg the mdu_op_t enum (MULT, MULTU, DIV, DIVU), the state enum, and the constant MDU_ITER=32.
REQ-029 SHALL isolate the combinational restoring-divide iteration in sub-module mdu_div_step, instantiated only under MDU_DIV_EN.

Verification
REQ-030 SHALL cover MULT 32'hFFFFFFFE (-2) x 32'h00000003 -> after 33 edges done=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-031 SHALL cover MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-032 SHALL cover DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; then DIVU 7 / 0 -> lo=32'hFFFFFFFF, hi=7, div_by_zero=1.
REQ-033 SHALL cover start and mtlo pulsed at iteration 10 of a MULTU 3 x 5 -> both ignored; result hi=0, lo=15; a later mthi with wr_data=32'hA5A5A5A5 in IDLE -> hi=32'hA5A5A5A5.
REQ-034 SHALL cover rst asserted at iteration 20 of DIV 100 / 7 -> next cycle IDLE, hi=lo=0, and no done pulse follows.
REQ-035 SHALL cover, without MDU_DIV_EN, start with op=DIVU -> busy stays 0, done never asserts, hi/lo unchanged.
